// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation engine: filtered hall decode, dead-time gated bridge drive,
// hall-edge period/stall measurement. Define HALL_SEQ_CHECK_EN for the sector-adjacency check.
module bldc_commutator #(
    parameter int DEADTIME_W  = 11,
    parameter int HALL_FILTER = 4,
    parameter int PERIOD_W    = 24
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic [2:0]            hall,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  brake,
    input  logic [DEADTIME_W-1:0] deadtime,
    input  logic                  pwm_in,
    output logic [2:0]            inh,
    output logic [2:0]            inl,
    output logic [2:0]            sector,
    output logic                  hall_fault,
    output logic [PERIOD_W-1:0]   period,
    output logic                  period_valid,
    output logic                  stall,
    output logic                  seq_error
);
    // state | meaning
    // OFF   | all gates off, waiting for enable and a non-zero target
    // DEAD  | all gates off, dead-time countdown before driving
    // DRIVE | gates follow the pattern latched on DEAD exit
    typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_DRIVE} state_t;

    localparam int FCNT_W = $clog2(HALL_FILTER + 1);
    localparam logic [PERIOD_W-1:0] PMAX = '1;

    state_t                state, state_nx;
    logic [2:0]            sync1, sync2, cand, cand_nx;
    logic [1:0]            primed;
    logic [FCNT_W-1:0]     fcnt, fcnt_nx;
    logic                  accept, sec_change, vv_change, to_valid;
    logic [2:0]            dec_sector;
    logic                  seq_hold;
    logic [5:0]            target, tgt_q, pat, pat_nx;
    logic [DEADTIME_W-1:0] dcnt, dcnt_nx;
    logic [2:0]            gate_h, gate_l;
    logic [PERIOD_W-1:0]   pcnt, pcnt_inc;

    // primed keeps the reset value of the synchroniser out of the filter
    always_comb begin
        cand_nx = cand;
        fcnt_nx = fcnt;
        if (primed[1]) begin
            if (fcnt == '0 || sync2 != cand) begin
                cand_nx = sync2;
                fcnt_nx = FCNT_W'(1);
            end else if (fcnt != FCNT_W'(HALL_FILTER)) begin
                fcnt_nx = fcnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (cand_nx)
            3'b101:  dec_sector = 3'd0;
            3'b100:  dec_sector = 3'd1;
            3'b110:  dec_sector = 3'd2;
            3'b010:  dec_sector = 3'd3;
            3'b011:  dec_sector = 3'd4;
            3'b001:  dec_sector = 3'd5;
            default: dec_sector = 3'd7;
        endcase
    end

    assign accept     = (fcnt_nx == FCNT_W'(HALL_FILTER));
    assign sec_change = accept && (dec_sector != sector);
    assign to_valid   = sec_change && (dec_sector != 3'd7);
    assign vv_change  = to_valid && (sector != 3'd7);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            primed     <= '0;
            cand       <= '0;
            fcnt       <= '0;
            sector     <= 3'd7;
            hall_fault <= 1'b0;
        end else begin
            sync1  <= hall;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            cand   <= cand_nx;
            fcnt   <= fcnt_nx;
            if (accept) begin
                sector     <= dec_sector;
                hall_fault <= (dec_sector == 3'd7);
            end
        end
    end

`ifdef HALL_SEQ_CHECK_EN
    function automatic logic [2:0] inc6(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    logic jump;
    assign jump = vv_change && !(dec_sector == inc6(sector) || sector == inc6(dec_sector));

    // seq_hold keeps the bridge off from a jump until the next well-formed change
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            seq_error <= 1'b0;
            seq_hold  <= 1'b0;
        end else begin
            if (jump) begin
                seq_error <= 1'b1;
                seq_hold  <= 1'b1;
            end else if (to_valid) begin
                seq_hold <= 1'b0;
            end
        end
    end
`else
    assign seq_error = 1'b0;
    assign seq_hold  = 1'b0;
`endif

    assign pcnt_inc = (pcnt == PMAX) ? pcnt : pcnt + 1'b1;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pcnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (vv_change) begin
                period       <= pcnt;
                pcnt         <= PERIOD_W'(1);
                period_valid <= 1'b1;
                stall        <= 1'b0;
            end else if (to_valid) begin
                pcnt  <= PERIOD_W'(1);
                stall <= 1'b0;
            end else begin
                pcnt <= pcnt_inc;
                if (pcnt_inc == PMAX) begin
                    stall  <= 1'b1;
                    period <= PMAX;
                end
            end
        end
    end

    // target = {high side C,B,A, low side C,B,A}
    always_comb begin
        target = '0;
        if (enable && sector != 3'd7) begin
            if (brake) begin
                target = 6'b000_111;
            end else begin
                case ({dir, sector})
                    4'b1_000: target = 6'b100_010;
                    4'b1_001: target = 6'b001_010;
                    4'b1_010: target = 6'b001_100;
                    4'b1_011: target = 6'b010_100;
                    4'b1_100: target = 6'b010_001;
                    4'b1_101: target = 6'b100_001;
                    4'b0_000: target = 6'b010_100;
                    4'b0_001: target = 6'b010_001;
                    4'b0_010: target = 6'b100_001;
                    4'b0_011: target = 6'b100_010;
                    4'b0_100: target = 6'b001_010;
                    4'b0_101: target = 6'b001_100;
                    default:  target = '0;
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        pat_nx   = pat;
        if (!enable || hall_fault || seq_hold) begin
            state_nx = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (target != '0) begin
                        state_nx = ST_DEAD;
                        dcnt_nx  = deadtime;
                    end
                end
                ST_DEAD: begin
                    if (target != tgt_q) begin
                        dcnt_nx = deadtime;
                    end else if (dcnt == '0) begin
                        state_nx = (target != '0) ? ST_DRIVE : ST_OFF;
                        pat_nx   = target;
                    end else begin
                        dcnt_nx = dcnt - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (target != pat) begin
                        state_nx = ST_DEAD;
                        dcnt_nx  = deadtime;
                    end
                end
                default: state_nx = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_OFF;
            dcnt   <= '0;
            pat    <= '0;
            tgt_q  <= '0;
            gate_h <= '0;
            gate_l <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            pat   <= pat_nx;
            tgt_q <= target;
            if (state_nx == ST_DRIVE) begin
                gate_h <= pat_nx[5:3];
                gate_l <= pat_nx[2:0];
            end else begin
                gate_h <= '0;
                gate_l <= '0;
            end
        end
    end

    assign inh = gate_h & {3{pwm_in}};
    assign inl = gate_l;

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: randomized hall/control stimulus against a
// behavioural model; expected outputs queued per cycle and checked by a separate monitor.
module tb_bldc_commutator;
    localparam int DW = 11;
    localparam int HF = 4;
    localparam int PW = 12;
    localparam longint PMAX = (longint'(1) << PW) - 1;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    hall = 3'b000;
    logic          enable = 1'b0, dir = 1'b1, brake = 1'b0, pwm_in = 1'b0;
    logic [DW-1:0] deadtime = '0;
    logic [2:0]    inh, inl, sector;
    logic          hall_fault, period_valid, stall, seq_error;
    logic [PW-1:0] period;

    bldc_commutator #(.DEADTIME_W(DW), .HALL_FILTER(HF), .PERIOD_W(PW)) dut (
        .CLK(CLK), .reset_n(reset_n), .hall(hall), .enable(enable), .dir(dir),
        .brake(brake), .deadtime(deadtime), .pwm_in(pwm_in), .inh(inh), .inl(inl),
        .sector(sector), .hall_fault(hall_fault), .period(period),
        .period_valid(period_valid), .stall(stall), .seq_error(seq_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]    inh, inl, sector;
        logic          fault, pv, stall, seqe;
        logic [PW-1:0] period;
    } exp_t;

    exp_t          expq[$];
    logic [PW-1:0] perq[$];
    int vectors = 0, miscompares = 0;

    // phase index 0=A 1=B 2=C per sector A..F
    int fwd_hi[6] = '{2, 0, 0, 1, 1, 2};
    int fwd_lo[6] = '{1, 1, 2, 2, 0, 0};
    int rev_hi[6] = '{1, 1, 2, 2, 0, 0};
    int rev_lo[6] = '{2, 0, 0, 1, 1, 2};
    int dec_tab[8] = '{7, 5, 3, 4, 1, 0, 2, 7};
    logic [2:0] enc_tab[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    longint     k, restart_k;
    logic [2:0] rawq[$], fsq[$];
    int         m_sector, dead_left;
    bit         m_fault, m_hold, m_seqe, m_stall, m_pv;
    logic [PW-1:0] m_period;
    logic [5:0] pat, prev_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_target(int s, logic en, logic d, logic b);
        logic [2:0] h, l;
        if (!en || s == 7) return 6'b0;
        if (b) return 6'b000_111;
        h = 3'b001 << (d ? fwd_hi[s] : rev_hi[s]);
        l = 3'b001 << (d ? fwd_lo[s] : rev_lo[s]);
        return {h, l};
    endfunction

    task automatic model_reset();
        k = 0; restart_k = 1;
        rawq.delete(); fsq.delete();
        m_sector = 7; m_fault = 0; m_hold = 0; m_seqe = 0;
        m_stall = 0; m_pv = 0; m_period = '0;
        dead_left = -2; pat = '0; prev_t = '0;
    endtask

    // dead_left: -2 bridge off, -1 driving pat, >=0 dead cycles still to count
    task automatic model_step();
        logic [5:0] t;
        int s_new, d;
        bit f_new, same, jump;
        longint p;
        exp_t e;
        k++;
        t = model_target(m_sector, enable, dir, brake);
        if (!enable || m_fault || m_hold) dead_left = -2;
        else if (dead_left == -2) begin
            if (t != 0) dead_left = int'(deadtime);
        end else if (dead_left == -1) begin
            if (t != pat) dead_left = int'(deadtime);
        end else if (t != prev_t) dead_left = int'(deadtime);
        else if (dead_left == 0) begin
            if (t != 0) begin dead_left = -1; pat = t; end
            else dead_left = -2;
        end else dead_left--;
        prev_t = t;

        s_new = m_sector; f_new = m_fault;
        rawq.push_back(hall);
        if (rawq.size() == 3) begin
            fsq.push_back(rawq.pop_front());
            if (fsq.size() > HF) void'(fsq.pop_front());
            same = (fsq.size() == HF);
            foreach (fsq[i]) if (fsq[i] != fsq[0]) same = 0;
            if (same) begin s_new = dec_tab[fsq[0]]; f_new = (s_new == 7); end
        end

        jump = 0;
`ifdef HALL_SEQ_CHECK_EN
        if (m_sector != 7 && s_new != 7 && s_new != m_sector) begin
            d = (s_new - m_sector + 6) % 6;
            if (d != 1 && d != 5) begin jump = 1; m_seqe = 1; end
        end
        if (jump) m_hold = 1;
        else if (s_new != m_sector && s_new != 7) m_hold = 0;
`else
        d = 0;
`endif

        m_pv = 0;
        if (s_new != m_sector && s_new != 7) begin
            if (m_sector != 7) begin
                p = k - restart_k;
                if (p > PMAX) p = PMAX;
                m_period = PW'(p);
                m_pv = 1;
                perq.push_back(m_period);
            end
            restart_k = k;
            m_stall = 0;
        end else if (k - restart_k + 1 >= PMAX) begin
            m_stall = 1;
            m_period = PW'(PMAX);
        end
        m_sector = s_new; m_fault = f_new;

        e.inh    = (dead_left == -1) ? (pat[5:3] & {3{pwm_in}}) : 3'b0;
        e.inl    = (dead_left == -1) ? pat[2:0] : 3'b0;
        e.sector = 3'(m_sector);
        e.fault  = m_fault;
        e.pv     = m_pv;
        e.stall  = m_stall;
        e.seqe   = m_seqe;
        e.period = m_period;
        expq.push_back(e);
    endtask

    // called at a negedge with inputs already set; returns at the following negedge
    task automatic cycle();
        pwm_in = 1'($urandom_range(0, 1));
        model_step();
        @(negedge CLK);
    endtask

    task automatic dwell(input logic [2:0] code, input int n);
        hall = code;
        repeat (n) cycle();
    endtask

    task automatic reset_check();
        reset_n = 1'b0;
        #1;
        chk("rst_inh", inh, 0);
        chk("rst_inl", inl, 0);
        chk("rst_sector", sector, 7);
        chk("rst_fault", hall_fault, 0);
        chk("rst_period", period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_seq_error", seq_error, 0);
        model_reset();
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("inh", inh, e.inh);
                chk("inl", inl, e.inl);
                chk("sector", sector, e.sector);
                chk("hall_fault", hall_fault, e.fault);
                chk("period", period, e.period);
                chk("period_valid", period_valid, e.pv);
                chk("stall", stall, e.stall);
                chk("seq_error", seq_error, e.seqe);
                chk("shoot_through", inh & inl, 0);
            end
            if (period_valid === 1'b1) begin
                if (perq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL period_strobe: got unexpected strobe expected none at %0t", $time);
                end else begin
                    chk("period_strobe", period, perq.pop_front());
                end
            end
        end
    end

    initial begin : driver
        int sec, r, n;
        @(negedge CLK);
        reset_check();

        // bring-up in sector A, forward, deadtime 10
        enable = 1; dir = 1; deadtime = DW'(10);
        dwell(3'b101, 40);
        // glitch shorter than the filter
        dwell(3'b100, 3);
        dwell(3'b101, 30);
        // forward rotation A->B->C, dir flip mid-drive
        dwell(3'b100, 1000);
        dwell(3'b110, 500);
        dir = 0;
        dwell(3'b110, 500);
        dwell(3'b100, 1000);
        // invalid code then recovery to D
        dwell(3'b111, 20);
        dwell(3'b010, 60);
        // stall: hold past 2^PW-1 cycles, then a valid change
        dwell(3'b010, 4200);
        dwell(3'b011, 100);
        // jump E->B then adjacent B->C
        dwell(3'b100, 100);
        dwell(3'b110, 100);

        sec = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 11) == 0) brake = ~brake;
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 1) == 0) enable = 1;
            if ($urandom_range(0, 6) == 0) deadtime = DW'($urandom_range(0, 20));
            r = $urandom_range(0, 99);
            n = $urandom_range(10, 400);
            if (r < 8) begin
                dwell(3'($urandom_range(0, 7)), $urandom_range(1, HF - 1));
                n = $urandom_range(5, 40);
            end else if (r < 14) begin
                dwell((r < 11) ? 3'b000 : 3'b111, $urandom_range(5, 30));
            end else if (r < 20) begin
                sec = (sec + $urandom_range(2, 3)) % 6;
            end else begin
                sec = dir ? (sec + 1) % 6 : (sec + 5) % 6;
            end
            if ($urandom_range(0, 5) == 0) begin
                dwell(enc_tab[sec], $urandom_range(1, 15));
                dir = ~dir;
            end
            dwell(enc_tab[sec], n);
        end

        repeat (2) cycle();
        chk("exp_queue_drained", expq.size(), 0);
        chk("period_queue_drained", perq.size(), 0);
        reset_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
